// File: rtl/vram_slot_arbiter_if.sv
// VRAM arbiter bus: scanout, CPU and VRAM macro signals.
// slave is the arbiter side, master the requesters/memory side.
interface vram_slot_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  disp_req;
    logic [ADDR_WIDTH-1:0] disp_addr;
    logic                  disp_ack;
    logic [DATA_WIDTH-1:0] disp_data;
    logic                  disp_miss;
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, cpu_req, cpu_we,
        input  cpu_addr, cpu_wdata, mem_rdata,
        output disp_ack, disp_data, disp_miss,
        output cpu_ack, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, cpu_req, cpu_we,
        output cpu_addr, cpu_wdata, mem_rdata,
        input  disp_ack, disp_data, disp_miss,
        input  cpu_ack, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_slot_arbiter.sv
// Slot-based arbiter sharing one VRAM port between scanout and CPU.
// Slot 0 of each pixel period belongs to scanout.
module vram_slot_arbiter #(
    parameter int DIVISION    = 4,
    parameter int SLOT_WIDTH  = 2,
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pixel_sync,
    output logic [SLOT_WIDTH-1:0] slot,
    vram_slot_arbiter_if.slave    bus
);
    localparam int LW = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
    localparam logic [SLOT_WIDTH-1:0] LAST = SLOT_WIDTH'(DIVISION - 1);
    // Latest slot a CPU access can start and still finish before slot 0
    localparam int CPU_LAST = DIVISION - 1 - MEM_LATENCY;

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {DISP, CPU} owner_t;

    state_t                state, state_n;
    owner_t                owner;
    logic [LW-1:0]         lat;
    logic                  rd_q;
    logic                  pend;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  disp_ok;
    logic                  cpu_ok;
    logic                  issue_disp;
    logic                  issue_cpu;
    logic                  done;

    always_comb begin
        state_n       = state;
        issue_disp    = 1'b0;
        issue_cpu     = 1'b0;
        done          = 1'b0;
        disp_ok       = bus.disp_req && !bus.disp_ack
                        && (slot == '0 || pend);
        cpu_ok        = bus.cpu_req && !bus.cpu_ack && !pend
                        && (int'(slot) <= CPU_LAST);
        bus.disp_miss = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (disp_ok)
                        issue_disp = 1'b1;
                    else if (cpu_ok)
                        issue_cpu = 1'b1;
                    if (issue_disp || issue_cpu)
                        state_n = BUSY;
                end
                BUSY: begin
                    bus.disp_miss = bus.disp_req && slot == '0;
                    if (lat == LW'(MEM_LATENCY)) begin
                        done    = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        bus.mem_en = issue_disp || issue_cpu;
        bus.mem_we = issue_cpu && bus.cpu_we;
        unique case (1'b1)
            issue_disp: begin
                bus.mem_addr  = bus.disp_addr;
                bus.mem_wdata = wdata_q;
            end
            issue_cpu: begin
                bus.mem_addr  = bus.cpu_addr;
                bus.mem_wdata = bus.cpu_wdata;
            end
            default: begin
                bus.mem_addr  = addr_q;
                bus.mem_wdata = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot          <= '0;
            state         <= IDLE;
            owner         <= DISP;
            lat           <= '0;
            rd_q          <= 1'b0;
            pend          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bus.disp_ack  <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.disp_data <= '0;
            bus.cpu_rdata <= '0;
        end else begin
            if (pixel_sync || slot == LAST)
                slot <= '0;
            else
                slot <= slot + SLOT_WIDTH'(1);
            state        <= state_n;
            bus.disp_ack <= done && owner == DISP;
            bus.cpu_ack  <= done && owner == CPU;
            if (issue_disp || issue_cpu) begin
                owner   <= issue_disp ? DISP : CPU;
                lat     <= LW'(1);
                rd_q    <= issue_disp || !bus.cpu_we;
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
            end else if (state == BUSY && !done) begin
                lat <= lat + LW'(1);
            end
            if (done && owner == DISP)
                bus.disp_data <= bus.mem_rdata;
            if (done && owner == CPU && rd_q)
                bus.cpu_rdata <= bus.mem_rdata;
            if (issue_disp)
                pend <= 1'b0;
            else if (bus.disp_miss)
                pend <= 1'b1;
        end
    end
endmodule
